// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter (core D-bus m0, debug SBA m1) onto one slave port.
// Define DBUS_ARB_RR_EN for round-robin ties; otherwise m1 has fixed priority.
module dbus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_bstart,
    input  logic [31:0] m0_addr,
    input  logic        m0_ttype,
    input  logic [1:0]  m0_tsize,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_bdone,
    output logic        m0_berr,

    input  logic        m1_bstart,
    input  logic [31:0] m1_addr,
    input  logic        m1_ttype,
    input  logic [1:0]  m1_tsize,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_bdone,
    output logic        m1_berr,

    output logic        s_bstart,
    output logic [31:0] s_addr,
    output logic        s_ttype,
    output logic [1:0]  s_tsize,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_bdone,

    output logic [1:0]  grant
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0] cnt;
    logic        req_any;
    logic        pick_m1;

    logic        do_latch;
    logic        do_issue;
    logic        do_count;
    logic        do_release;
    logic        hit;
    logic        tmo;
    logic        finish;

    logic [31:0] sel_addr;
    logic        sel_ttype;
    logic [1:0]  sel_tsize;
    logic [31:0] sel_wdata;

    assign req_any = m0_bstart | m1_bstart;

`ifdef DBUS_ARB_RR_EN
    // rr_m1 set means m1 wins the next tie; it follows whoever finished last
    logic rr_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_m1 <= 1'b0;
        end else if (state == DONE) begin
            rr_m1 <= grant[0];
        end
    end

    always_comb begin
        pick_m1 = m1_bstart & (~m0_bstart | rr_m1);
    end
`else
    always_comb begin
        pick_m1 = m1_bstart;
    end
`endif

    always_comb begin
        sel_addr  = m0_addr;
        sel_ttype = m0_ttype;
        sel_tsize = m0_tsize;
        sel_wdata = m0_wdata;
        unique case (1'b1)
            pick_m1: begin
                sel_addr  = m1_addr;
                sel_ttype = m1_ttype;
                sel_tsize = m1_tsize;
                sel_wdata = m1_wdata;
            end
            default: begin
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (req_any) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (finish) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        do_latch   = 1'b0;
        do_issue   = 1'b0;
        do_count   = 1'b0;
        do_release = 1'b0;
        hit        = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            IDLE:  do_latch = req_any;
            ISSUE: do_issue = 1'b1;
            WAIT: begin
                hit      = s_bdone;
                tmo      = ~s_bdone & (cnt == TMO_LAST);
                do_count = ~s_bdone & (cnt != TMO_LAST);
            end
            DONE:  do_release = 1'b1;
            default: begin
            end
        endcase
    end

    assign finish = hit | tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 2'b00;
            s_addr  <= 32'd0;
            s_ttype <= 1'b0;
            s_tsize <= 2'd0;
            s_wdata <= 32'd0;
        end else if (do_latch) begin
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            s_addr  <= sel_addr;
            s_ttype <= sel_ttype;
            s_tsize <= sel_tsize;
            s_wdata <= sel_wdata;
        end else if (do_release) begin
            grant   <= 2'b00;
        end
    end

    // s_bstart is registered, giving the two-cycle request latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bstart <= 1'b0;
        end else begin
            s_bstart <= do_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (do_issue) begin
            cnt <= 16'd0;
        end else if (do_count) begin
            cnt <= cnt + 16'd1;
        end
    end

    // completion is registered on WAIT exit so it is visible during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_bdone <= 1'b0;
            m0_berr  <= 1'b0;
            m0_rdata <= 32'd0;
            m1_bdone <= 1'b0;
            m1_berr  <= 1'b0;
            m1_rdata <= 32'd0;
        end else begin
            m0_bdone <= finish & grant[0];
            m0_berr  <= tmo & grant[0];
            m0_rdata <= (hit & grant[0]) ? s_rdata : 32'd0;
            m1_bdone <= finish & grant[1];
            m1_berr  <= tmo & grant[1];
            m1_rdata <= (hit & grant[1]) ? s_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter; slave model answers with ~s_addr.
// Works with or without DBUS_ARB_RR_EN defined.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_bstart, m1_bstart;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ttype, m1_ttype;
    logic [1:0]  m0_tsize, m1_tsize;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_bdone, m1_bdone, m0_berr, m1_berr;
    logic        s_bstart, s_ttype, s_bdone;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  s_tsize, grant;

    dbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_bstart(m0_bstart), .m0_addr(m0_addr), .m0_ttype(m0_ttype),
        .m0_tsize(m0_tsize), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_bdone(m0_bdone), .m0_berr(m0_berr),
        .m1_bstart(m1_bstart), .m1_addr(m1_addr), .m1_ttype(m1_ttype),
        .m1_tsize(m1_tsize), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_bdone(m1_bdone), .m1_berr(m1_berr),
        .s_bstart(s_bstart), .s_addr(s_addr), .s_ttype(s_ttype),
        .s_tsize(s_tsize), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_bdone(s_bdone), .grant(grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   m0_left = 0;
    int   m1_left = 0;
    int   done_cyc = 0;
    int   sbd_cyc = 0;
    int   slave_dly = 3;
    logic slave_mute = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_done(input int m, input logic [31:0] rd,
                               input logic err);
        exp_t e;
        e.m = m;
        e.rd = rd;
        e.err = err;
        sbq.push_back(e);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    // one cycle: sample at negedge, score completions, let masters retire
    task automatic step();
        exp_t e;
        int   who;
        @(negedge clk);
        if (m0_bdone || m1_bdone) begin
            done_cyc = cyc;
            who = m1_bdone ? 1 : 0;
            chk("one_done", 64'(m0_bdone & m1_bdone), 64'd0);
            if (sbq.size() == 0) begin
                chk("unexp_done", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("done_who", 64'(who), 64'(e.m));
                if (who == 1) begin
                    chk("m1_rdata", 64'(m1_rdata), 64'(e.rd));
                    chk("m1_berr", 64'(m1_berr), 64'(e.err));
                    chk("m0_quiet", {31'd0, m0_berr, m0_rdata}, 64'd0);
                end else begin
                    chk("m0_rdata", 64'(m0_rdata), 64'(e.rd));
                    chk("m0_berr", 64'(m0_berr), 64'(e.err));
                    chk("m1_quiet", {31'd0, m1_berr, m1_rdata}, 64'd0);
                end
            end
            if (m0_bdone) begin
                if (m0_left > 1) m0_left--;
                else begin
                    m0_left = 0;
                    m0_bstart = 1'b0;
                end
            end
            if (m1_bdone) begin
                if (m1_left > 1) m1_left--;
                else begin
                    m1_left = 0;
                    m1_bstart = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sbq.size() > 0 && n < bound) begin
            step();
            n++;
        end
        if (sbq.size() > 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    // slave: answers s_bdone slave_dly cycles after s_bstart unless muted
    initial begin
        s_bdone = 1'b0;
        s_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (s_bstart && rst_n && !slave_mute) begin
                repeat (slave_dly) @(negedge clk);
                s_bdone = 1'b1;
                s_rdata = ~s_addr;
                sbd_cyc = cyc;
                @(negedge clk);
                s_bdone = 1'b0;
                s_rdata = 32'd0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sbc;
        int rel;
        logic seen;
        m0_bstart = 0; m1_bstart = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_ttype = 0; m1_ttype = 0; m0_tsize = 0; m1_tsize = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_sbstart", 64'(s_bstart), 64'd0);
        chk("rst_saddr", 64'(s_addr), 64'd0);
        chk("rst_done", {60'd0, m0_bdone, m1_bdone, m0_berr, m1_berr}, 64'd0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst_n = 1'b1;
        at_edge();

        // single m0 word read
        m0_addr = 32'h8000_0010; m0_ttype = 0; m0_tsize = 2'd2;
        m0_left = 1; m0_bstart = 1;
        expect_done(0, ~32'h8000_0010, 1'b0);
        step();
        chk("t1_pre_grant", 64'(grant), 64'd0);
        step();
        chk("t1_grant", 64'(grant), 64'b01);
        chk("t1_sb_early", 64'(s_bstart), 64'd0);
        step();
        chk("t1_sbstart", 64'(s_bstart), 64'd1);
        chk("t1_saddr", 64'(s_addr), 64'h8000_0010);
        chk("t1_ttsz", {61'd0, s_ttype, s_tsize}, 64'd2);
        step();
        chk("t1_sb_pulse", 64'(s_bstart), 64'd0);
        drain(40);
        chk("t1_done_lat", 64'(done_cyc - sbd_cyc), 64'd1);
        at_edge();
        chk("t1_idle", 64'(grant), 64'd0);

        // simultaneous requests: m1 first
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        m0_left = 1; m1_left = 1;
        m0_bstart = 1; m1_bstart = 1;
        expect_done(1, ~32'h0000_0200, 1'b0);
        expect_done(0, ~32'h0000_0100, 1'b0);
        step();
        step();
        chk("t2_grant", 64'(grant), 64'b10);
        drain(60);
        at_edge();

        // timeout on m1 write; inputs change and drop after latching
        slave_mute = 1;
        m1_addr = 32'h1000_0000; m1_ttype = 1; m1_tsize = 2'd2;
        m1_wdata = 32'hDEAD_BEEF; m1_left = 1; m1_bstart = 1;
        expect_done(1, 32'd0, 1'b1);
        step();
        step();
        m1_bstart = 0; m1_wdata = 32'd0; m1_addr = 32'hFFFF_FFFF;
        step();
        chk("t3_sbstart", 64'(s_bstart), 64'd1);
        chk("t3_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("t3_addr", 64'(s_addr), 64'h1000_0000);
        chk("t3_ttype", 64'(s_ttype), 64'd1);
        sbc = cyc;
        drain(40);
        chk("t3_tmo_lat", 64'(done_cyc - sbc), 64'd8);
        at_edge();
        chk("t3_idle", 64'(grant), 64'd0);

        // reset while waiting on the slave
        m0_addr = 32'h2000_0040; m0_ttype = 0; m0_tsize = 2'd1;
        m0_left = 1; m0_bstart = 1;
        repeat (5) step();
        chk("t4_in_wait", 64'(grant), 64'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_grant", 64'(grant), 64'd0);
        chk("t4_rst_sb", {31'd0, s_bstart, s_addr}, 64'd0);
        chk("t4_rst_done", {62'd0, m0_bdone, m0_berr}, 64'd0);
        repeat (2) step();
        slave_mute = 0;
        expect_done(0, ~32'h2000_0040, 1'b0);
        at_edge();
        rst_n = 1'b1;
        rel = cyc;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (s_bstart) seen = 1'b1;
        end
        chk("t4_reissue", 64'(seen), 64'd1);
        chk("t4_reissue_lat", 64'(cyc - rel), 64'd2);
        drain(40);
        at_edge();

        // both masters keep requesting for two transactions each
        m0_addr = 32'h3000_0000; m1_addr = 32'h3000_0004;
        m0_left = 2; m1_left = 2;
        m0_bstart = 1; m1_bstart = 1;
`ifdef DBUS_ARB_RR_EN
        expect_done(1, ~32'h3000_0004, 1'b0);
        expect_done(0, ~32'h3000_0000, 1'b0);
        expect_done(1, ~32'h3000_0004, 1'b0);
        expect_done(0, ~32'h3000_0000, 1'b0);
`else
        expect_done(1, ~32'h3000_0004, 1'b0);
        expect_done(1, ~32'h3000_0004, 1'b0);
        expect_done(0, ~32'h3000_0000, 1'b0);
        expect_done(0, ~32'h3000_0000, 1'b0);
`endif
        drain(120);
        at_edge();
        chk("t5_idle", {62'd0, grant}, 64'd0);
        chk("t5_released", {62'd0, m0_bstart, m1_bstart}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
